norm_row_stats: RTL

NORM_ROW_STATS -- requirements
Module: norm_row_stats

---
 rtl/norm_pkg.sv | 28 ++
 rtl/norm_lane_sq_tree.sv | 45 ++++
 rtl/norm_row_stats.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/norm_pkg.sv
// Shared definitions for the row-normalisation statistics path: lane geometry,
// output field layout, FSM encoding and the per-element square helper.
package norm_pkg;

    localparam int LANES     = 8;
    localparam int ELEM_W    = 16;
    localparam int MEAN_LSB  = 0;
    localparam int VAR_LSB   = 16;
    localparam int VAR_W     = 32;
    localparam int OUT_W     = 64;
    localparam int S1_SUM_W  = ELEM_W + $clog2(LANES);
    localparam int S1_SQ_W   = 2 * ELEM_W + $clog2(LANES) - 1;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Square of a signed element; the result never exceeds 2^30, so 32 bits suffice.
    function automatic logic [31:0] elem_sq(input logic signed [ELEM_W-1:0] x);
        logic signed [31:0] xe;
        xe = {{16{x[ELEM_W-1]}}, x};
        return xe * xe;
    endfunction

endpackage

// File: rtl/norm_lane_sq_tree.sv
// Stage 1: registered sum and sum-of-squares across all lanes of one accepted beat.
module norm_lane_sq_tree
    import norm_pkg::*;
(
    input  logic                      aclk,
    input  logic                      arstn,
    input  logic [LANES*ELEM_W-1:0]   i_data,
    input  logic                      i_en,
    output logic [S1_SUM_W-1:0]       o_sum,
    output logic [S1_SQ_W-1:0]        o_sumsq,
    output logic                      o_valid
);

    logic [ELEM_W-1:0]   w_lane;
    logic [S1_SUM_W-1:0] w_sum;
    logic [S1_SQ_W-1:0]  w_sq;

    // Combinational adder tree over the lanes.
    always_comb begin
        w_lane = '0;
        w_sum  = '0;
        w_sq   = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane = i_data[i*ELEM_W +: ELEM_W];
            w_sum  = w_sum + {{(S1_SUM_W-ELEM_W){w_lane[ELEM_W-1]}}, w_lane};
            w_sq   = w_sq + {{(S1_SQ_W-32){1'b0}}, elem_sq(w_lane)};
        end
    end

    // Capture the beat result; valid marks a fresh result for the accumulators.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            o_sum   <= '0;
            o_sumsq <= '0;
            o_valid <= 1'b0;
        end else if (i_en) begin
            o_sum   <= w_sum;
            o_sumsq <= w_sq;
            o_valid <= 1'b1;
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/norm_row_stats.sv
// Per-row mean and variance of a stream of 8-lane signed 16-bit beats:
// accumulate a fixed-length row, finalise, then hold the result until taken.
module norm_row_stats
    import norm_pkg::*;
#(
    parameter int ROW_BEATS = 64
)(
    input  logic                     aclk,
    input  logic                     arstn,
    input  logic [LANES*ELEM_W-1:0]  S_AXIS_TDATA,
    input  logic                     S_AXIS_TVALID,
    input  logic                     S_AXIS_TLAST,
    output logic                     S_AXIS_TREADY,
    output logic [OUT_W-1:0]         M_AXIS_TDATA,
    output logic                     M_AXIS_TVALID,
    input  logic                     M_AXIS_TREADY,
    output logic                     err_tlast
);

    localparam int CNT_W = $clog2(ROW_BEATS);
    localparam int SH    = CNT_W + $clog2(LANES);
    localparam int SUM_W = (20 + CNT_W > 26) ? 20 + CNT_W : 26;
    localparam int SQ_W  = (35 + CNT_W > 44) ? 35 + CNT_W : 44;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ROW_BEATS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_fin_ph;
    logic                   r_s_tready;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_err;
    logic signed [SUM_W-1:0] r_sum;
    logic [SQ_W-1:0]        r_sumsq;
    logic signed [ELEM_W-1:0] r_mean;
    logic [VAR_W-1:0]       r_ex2;
    logic [VAR_W-1:0]       r_var;
    logic                   r_m_tvalid;
    logic [OUT_W-1:0]       r_m_tdata;

    logic                   w_accept;
    logic                   w_last_beat;
    logic                   w_out_hs;
    logic [S1_SUM_W-1:0]    w_s1_sum;
    logic [S1_SQ_W-1:0]     w_s1_sumsq;
    logic                   w_s1_valid;
    logic signed [31:0]     w_mean_ext;
    logic signed [31:0]     w_mm;
    logic [VAR_W:0]         w_diff;
    logic [VAR_W-1:0]       w_var;
    logic [OUT_W-1:0]       w_tdata;

    assign w_accept    = S_AXIS_TVALID && r_s_tready;
    assign w_last_beat = (r_cnt == LAST_BEAT);
    assign w_out_hs    = (r_state == ST_OUT) && r_m_tvalid && M_AXIS_TREADY;

    norm_lane_sq_tree u_tree (
        .aclk    (aclk),
        .arstn   (arstn),
        .i_data  (S_AXIS_TDATA),
        .i_en    (w_accept),
        .o_sum   (w_s1_sum),
        .o_sumsq (w_s1_sumsq),
        .o_valid (w_s1_valid)
    );

    // Next-state logic for the row sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: if (w_accept && w_last_beat) w_state_nxt = ST_DRAIN;
                      else                          w_state_nxt = ST_ACCUM;
            ST_DRAIN: w_state_nxt = ST_FINAL;
            ST_FINAL: if (r_fin_ph) w_state_nxt = ST_OUT;
                      else          w_state_nxt = ST_FINAL;
            ST_OUT:   if (w_out_hs) w_state_nxt = ST_ACCUM;
                      else          w_state_nxt = ST_OUT;
            default:  w_state_nxt = ST_ACCUM;
        endcase
    end

    // State register; TREADY is registered from the next state so it never sees M_AXIS_TREADY combinationally.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_state    <= ST_ACCUM;
            r_fin_ph   <= 1'b0;
            r_s_tready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_fin_ph   <= (r_state == ST_FINAL) && !r_fin_ph;
            r_s_tready <= (w_state_nxt == ST_ACCUM);
        end
    end

    // Beat counter defines the row length; TLAST is only cross-checked.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= w_last_beat ? '0 : r_cnt + CNT_W'(1);
            if (S_AXIS_TLAST != w_last_beat) r_err <= 1'b1;
        end
    end

    // Row accumulators, emptied once the result has been taken.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_sum   <= '0;
            r_sumsq <= '0;
        end else if (w_out_hs) begin
            r_sum   <= '0;
            r_sumsq <= '0;
        end else if (w_s1_valid) begin
            r_sum   <= r_sum + {{(SUM_W-S1_SUM_W){w_s1_sum[S1_SUM_W-1]}}, w_s1_sum};
            r_sumsq <= r_sumsq + {{(SQ_W-S1_SQ_W){1'b0}}, w_s1_sumsq};
        end
    end

    // Variance from E[x^2] - mean^2; flooring both terms can make it dip below zero.
    always_comb begin
        w_mean_ext = {{16{r_mean[ELEM_W-1]}}, r_mean};
        w_mm       = w_mean_ext * w_mean_ext;
        w_diff     = {1'b0, r_ex2} - {1'b0, w_mm};
        if (w_diff[VAR_W]) w_var = '0;
        else               w_var = w_diff[VAR_W-1:0];
    end

    // Two finalisation cycles: slicing above SH is the floor-division by the element count.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_mean <= '0;
            r_ex2  <= '0;
            r_var  <= '0;
        end else if (r_state == ST_FINAL && !r_fin_ph) begin
            r_mean <= r_sum[SH+ELEM_W-1:SH];
            r_ex2  <= r_sumsq[SH+VAR_W-1:SH];
        end else if (r_state == ST_FINAL && r_fin_ph) begin
            r_var  <= w_var;
        end
    end

    // Pack the result fields.
    always_comb begin
        w_tdata = '0;
        w_tdata[MEAN_LSB +: ELEM_W] = r_mean;
        w_tdata[VAR_LSB +: VAR_W]   = r_var;
    end

    // Output register: loads on entering OUT, holds until handshake, zero otherwise.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
        end else if (r_state == ST_OUT) begin
            if (!r_m_tvalid) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_tdata;
            end else if (M_AXIS_TREADY) begin
                r_m_tvalid <= 1'b0;
                r_m_tdata  <= '0;
            end
        end else begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
        end
    end

    assign S_AXIS_TREADY = r_s_tready;
    assign M_AXIS_TVALID = r_m_tvalid;
    assign M_AXIS_TDATA  = r_m_tdata;
    assign err_tlast     = r_err;

endmodule
